tt_pad_cfg_ctrl: RTL and testbench
==================================

# tt_pad_cfg_ctrl

Parametrised pad-control block that drives N_CH bidirectional GF180 pad cells (A, OE, IE, SL, CS, PD, PU per channel) from a serially loaded configuration chain. Configuration is shifted into a staging register and committed through a break-before-make sequencer, so an output driver is never enabled while its pulls or mode are changing. Pad inputs are synchronised and gated by IE before reaching the core. The block sits between the user-project mux and the pad ring, one instance per pad bank.

## Interface
- N_CH, default 8: number of pad channels (1..32).
- SYNC_STAGES, default 2: synchroniser depth on pad_Y (2..3).
- clk  in  1  block clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_sdi  in  1  serial config data.
- cfg_shift  in  1  shift-enable; one bit accepted per cycle.
- cfg_latch  in  1  commit request (level, sampled per cycle).
- cfg_sdo  out  1  MSB of the staging register, for daisy-chaining banks.
- busy  out  1  commit sequence in progress.
- cnt_err  out  1  last commit attempt had the wrong bit count.
- core_out  in  N_CH  output data from the core.
- core_in  out  N_CH  synchronised, IE-gated pad input to the core.
- pad_Y  in  N_CH  raw pad input.
- pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU  out  N_CH each  pad-cell controls.

## Operation
- Staging register sr, L = 6*N_CH bits. On cfg_shift: sr <= {sr[L-2:0], cfg_sdi}; cfg_sdo = sr[L-1].
- Bit map: channel c, field f at sr[6*c+f]. Field order: OE=0, IE=1, SL=2, CS=3, PD=4, PU=5.
- The bit counter increments on each shift and saturates at L+1. It clears on every sampled latch, whether accepted or rejected.
- Latch handling, when cfg_latch=1 and busy=0:
  - Count == L: accepted. shadow <= sr, cnt_err <= 0, enter OE_OFF.
  - Count != L: rejected. Pad outputs unchanged, cnt_err <= 1.
- cfg_latch while busy=1 is ignored, and the counter is not cleared.
- Latch and shift in the same cycle: the latch takes priority and the shift is dropped (sr and count do not advance).
- Shifting while busy is allowed. The sequencer uses only shadow.
- FSM: IDLE -> OE_OFF -> CFG -> OE_ON -> IDLE, one cycle per state.
  - OE_OFF: pad_OE <= pad_OE & shadow.OE, so only channels turning off are released.
  - CFG: pad_IE/SL/CS/PD/PU <= shadow fields.
  - OE_ON: pad_OE <= shadow.OE.
- busy = (state != IDLE).
- pad_A <= core_out every cycle, independent of OE.
- core_in = sync(pad_Y) & pad_IE, with a SYNC_STAGES-flop synchroniser per channel.
- Reset values:
  - pad_OE=0, pad_IE=0, pad_SL=0, pad_CS=0, pad_PD=all-1, pad_PU=0, pad_A=0.
  - sr=0, shadow=0, count=0, cnt_err=0, state=IDLE, sync flops=0.
  - Hence core_in=0 and cfg_sdo=0.
- Reset mid-sequence: all of the above values are forced asynchronously. There is no partial commit.

## Timing
- Accept at edge k. busy=1 from k to k+3.
- pad_OE is reduced after edge k+1. The other fields update after edge k+2. The final pad_OE appears after edge k+3.
- The earliest next accepted latch is at edge k+4.
- pad_A lags core_out by 1 cycle.
- core_in lags pad_Y by SYNC_STAGES cycles. The IE gate is combinational from the pad_IE register.
- cfg_sdo changes one clk-to-q after a shift edge.

## Structure
- Package tt_pad_pkg holds:
  - CFG_W=6.
  - Field-index localparams F_OE..F_PU.
  - Per-field reset constants.
  - FSM state enum pad_seq_t (IDLE, OE_OFF, CFG, OE_ON).
- Sub-module tt_pad_sync: a vector synchroniser of width N_CH and depth SYNC_STAGES, with async active-low reset to 0.

## Test plan
- Reset check: after reset with N_CH=8, pad_PD=8'hFF, all other pad outputs are 0, core_in=0, busy=0.
- Valid commit: shift 48 bits setting ch0 OE=1, IE=1, PU=1, then latch.
  - busy is high for 3 cycles.
  - pad_IE[0] and pad_PU[0] rise after edge k+2.
  - pad_OE[0] rises after edge k+3.
- Bad count: shift 47 bits, then latch. Outputs are unchanged and cnt_err=1. Then shift 48 bits and latch: the commit succeeds and cnt_err=0.
- Break-before-make: with ch3 currently OE=1, PD=0, commit ch3 OE=0, PD=1.
  - pad_OE[3] falls at k+1, strictly before pad_PD[3] rises at k+2.
  - No cycle has OE=1 with PD=1.
- Busy and collisions:
  - Latch pulses at k+1..k+3 are ignored.
  - A latch and a shift in the same cycle leave sr unchanged.
  - Reset asserted at k+2 restores all reset values immediately.
- Input path: with IE=0, toggling pad_Y[5] leaves core_in[5]=0. After IE=1, core_in[5] follows pad_Y[5] with 2-cycle latency.

Source files
------------

// File: rtl/tt_pad_pkg.sv
// Shared constants and types for the GF180 pad-bank configuration controller.
package tt_pad_pkg;

    localparam int CFG_W = 6;

    localparam int F_OE = 0;
    localparam int F_IE = 1;
    localparam int F_SL = 2;
    localparam int F_CS = 3;
    localparam int F_PD = 4;
    localparam int F_PU = 5;

    // Pulls default to pull-down so an unconfigured pad never floats.
    localparam logic RST_OE = 1'b0;
    localparam logic RST_IE = 1'b0;
    localparam logic RST_SL = 1'b0;
    localparam logic RST_CS = 1'b0;
    localparam logic RST_PD = 1'b1;
    localparam logic RST_PU = 1'b0;
    localparam logic RST_A  = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OE_OFF = 2'd1,
        CFG    = 2'd2,
        OE_ON  = 2'd3
    } pad_seq_t;

endpackage

// File: rtl/tt_pad_cfg_ctrl_sync.sv
// Vector synchroniser for raw pad inputs; every flop resets to 0.
module tt_pad_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/tt_pad_cfg_ctrl.sv
// Pad-bank controller: serial config chain, break-before-make commit, synced input path.
//   state  | meaning
//   IDLE   | waiting for a latch; pads hold last committed config
//   OE_OFF | release drivers of channels whose OE is turning off
//   CFG    | apply IE/SL/CS/PD/PU from shadow
//   OE_ON  | apply final OE from shadow
import tt_pad_pkg::*;

module tt_pad_cfg_ctrl #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_sdi,
    input  logic            cfg_shift,
    input  logic            cfg_latch,
    output logic            cfg_sdo,
    output logic            busy,
    output logic            cnt_err,
    input  logic [N_CH-1:0] core_out,
    output logic [N_CH-1:0] core_in,
    input  logic [N_CH-1:0] pad_Y,
    output logic [N_CH-1:0] pad_A,
    output logic [N_CH-1:0] pad_OE,
    output logic [N_CH-1:0] pad_IE,
    output logic [N_CH-1:0] pad_SL,
    output logic [N_CH-1:0] pad_CS,
    output logic [N_CH-1:0] pad_PD,
    output logic [N_CH-1:0] pad_PU
);

    localparam int L     = CFG_W * N_CH;
    localparam int CNT_W = $clog2(L + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(L + 1);

    pad_seq_t         state_q;
    logic [L-1:0]     sr_q, sr_d;
    logic [L-1:0]     shadow_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_err_q;
    logic [N_CH-1:0]  pad_a_q, pad_oe_q, pad_ie_q, pad_sl_q, pad_cs_q, pad_pd_q, pad_pu_q;
    logic [N_CH-1:0]  sh_oe, sh_ie, sh_sl, sh_cs, sh_pd, sh_pu;
    logic [N_CH-1:0]  y_sync;
    logic             latch_req, shift_req;

    // A latch seen while busy is invisible, so a concurrent shift still goes through.
    assign latch_req = cfg_latch && (state_q == IDLE);
    assign shift_req = cfg_shift && !latch_req;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (latch_req) begin
            cnt_d = '0;
        end else if (shift_req) begin
            sr_d = {sr_q[L-2:0], cfg_sdi};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        sh_oe = '0;
        sh_ie = '0;
        sh_sl = '0;
        sh_cs = '0;
        sh_pd = '0;
        sh_pu = '0;
        for (int c = 0; c < N_CH; c++) begin
            sh_oe[c] = shadow_q[CFG_W*c + F_OE];
            sh_ie[c] = shadow_q[CFG_W*c + F_IE];
            sh_sl[c] = shadow_q[CFG_W*c + F_SL];
            sh_cs[c] = shadow_q[CFG_W*c + F_CS];
            sh_pd[c] = shadow_q[CFG_W*c + F_PD];
            sh_pu[c] = shadow_q[CFG_W*c + F_PU];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            shadow_q  <= '0;
            cnt_q     <= '0;
            cnt_err_q <= 1'b0;
            pad_a_q   <= {N_CH{RST_A}};
            pad_oe_q  <= {N_CH{RST_OE}};
            pad_ie_q  <= {N_CH{RST_IE}};
            pad_sl_q  <= {N_CH{RST_SL}};
            pad_cs_q  <= {N_CH{RST_CS}};
            pad_pd_q  <= {N_CH{RST_PD}};
            pad_pu_q  <= {N_CH{RST_PU}};
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            pad_a_q <= core_out;
            case (state_q)
                IDLE: begin
                    if (latch_req) begin
                        if (cnt_q == CNT_FULL) begin
                            shadow_q  <= sr_q;
                            cnt_err_q <= 1'b0;
                            state_q   <= OE_OFF;
                        end else begin
                            cnt_err_q <= 1'b1;
                        end
                    end
                end
                OE_OFF: begin
                    pad_oe_q <= pad_oe_q & sh_oe;
                    state_q  <= CFG;
                end
                CFG: begin
                    pad_ie_q <= sh_ie;
                    pad_sl_q <= sh_sl;
                    pad_cs_q <= sh_cs;
                    pad_pd_q <= sh_pd;
                    pad_pu_q <= sh_pu;
                    state_q  <= OE_ON;
                end
                OE_ON: begin
                    pad_oe_q <= sh_oe;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tt_pad_sync #(
        .WIDTH  (N_CH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pad_Y),
        .q_o   (y_sync)
    );

    assign core_in = y_sync & pad_ie_q;
    assign cfg_sdo = sr_q[L-1];
    assign busy    = (state_q != IDLE);
    assign cnt_err = cnt_err_q;
    assign pad_A   = pad_a_q;
    assign pad_OE  = pad_oe_q;
    assign pad_IE  = pad_ie_q;
    assign pad_SL  = pad_sl_q;
    assign pad_CS  = pad_cs_q;
    assign pad_PD  = pad_pd_q;
    assign pad_PU  = pad_pu_q;

endmodule

// File: tb/tb_tt_pad_cfg_ctrl.sv
// Scoreboard bench for tt_pad_cfg_ctrl with N_CH=8, SYNC_STAGES=2.
module tb_tt_pad_cfg_ctrl;

    localparam int N = 8;
    localparam int L = 48;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_sdi = 1'b0, cfg_shift = 1'b0, cfg_latch = 1'b0;
    logic cfg_sdo, busy, cnt_err;
    logic [N-1:0] core_out = '0, pad_Y = '0;
    logic [N-1:0] core_in, pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU;

    always #5 clk = ~clk;

    tt_pad_cfg_ctrl #(.N_CH(N), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_sdi   (cfg_sdi),
        .cfg_shift (cfg_shift),
        .cfg_latch (cfg_latch),
        .cfg_sdo   (cfg_sdo),
        .busy      (busy),
        .cnt_err   (cnt_err),
        .core_out  (core_out),
        .core_in   (core_in),
        .pad_Y     (pad_Y),
        .pad_A     (pad_A),
        .pad_OE    (pad_OE),
        .pad_IE    (pad_IE),
        .pad_SL    (pad_SL),
        .pad_CS    (pad_CS),
        .pad_PD    (pad_PD),
        .pad_PU    (pad_PU)
    );

    typedef struct packed {
        logic         busy;
        logic         err;
        logic [N-1:0] oe, ie, sl, cs, pd, pu;
    } snap_t;

    snap_t        exp_q[$];
    logic [N-1:0] cin_q[$];
    logic [N-1:0] a_q[$];
    snap_t        m, rst_snap;
    int           checks = 0;
    int           fails  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.busy = busy;
        s.err  = cnt_err;
        s.oe   = pad_OE;
        s.ie   = pad_IE;
        s.sl   = pad_SL;
        s.cs   = pad_CS;
        s.pd   = pad_PD;
        s.pu   = pad_PU;
        return s;
    endfunction

    function automatic logic [N-1:0] fld(input logic [L-1:0] c, input int f);
        logic [N-1:0] r;
        r = '0;
        for (int ch = 0; ch < N; ch++) r[ch] = c[6*ch + f];
        return r;
    endfunction

    function automatic logic [L-1:0] setb(input logic [L-1:0] c, input int ch, input int f);
        logic [L-1:0] one;
        one = 1;
        return c | (one << (6*ch + f));
    endfunction

    task automatic shift_bits(input logic [L-1:0] c, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_shift = 1'b1;
            cfg_sdi   = c[i];
            tick();
        end
        cfg_shift = 1'b0;
        cfg_sdi   = 1'b0;
    endtask

    // Expected snapshots after edges k..k+3 of an accepted commit, or after k of a rejected one.
    task automatic push_commit(input logic [L-1:0] c, input bit ok);
        snap_t e;
        e = m;
        if (!ok) begin
            e.err = 1'b1;
            exp_q.push_back(e);
        end else begin
            e.busy = 1'b1;
            e.err  = 1'b0;
            exp_q.push_back(e);
            e.oe = m.oe & fld(c, 0);
            exp_q.push_back(e);
            e.ie = fld(c, 1);
            e.sl = fld(c, 2);
            e.cs = fld(c, 3);
            e.pd = fld(c, 4);
            e.pu = fld(c, 5);
            exp_q.push_back(e);
            e.oe   = fld(c, 0);
            e.busy = 1'b0;
            exp_q.push_back(e);
        end
        m = e;
    endtask

    task automatic test_reset();
        snap_t obs, e;
        rst_n    = 1'b0;
        core_out = 8'h5A;
        pad_Y    = 8'hFF;
        tick();
        tick();
        exp_q.push_back(rst_snap);
        obs = snap();
        e   = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            fails++;
            $display("FAIL reset_state: got %h need %h", obs, e);
        end
        checks++;
        if (core_in !== 8'h00) begin
            fails++;
            $display("FAIL reset_core_in: got %h need 00", core_in);
        end
        checks++;
        if (pad_A !== 8'h00 || cfg_sdo !== 1'b0) begin
            fails++;
            $display("FAIL reset_a_sdo: got A=%h sdo=%b need A=00 sdo=0", pad_A, cfg_sdo);
        end
        core_out = '0;
        pad_Y    = '0;
        rst_n    = 1'b1;
        m        = rst_snap;
        tick();
    endtask

    task automatic test_valid_commit();
        logic [L-1:0] c;
        snap_t obs, e;
        int nbusy;
        c = '0;
        c = setb(c, 0, 0);
        c = setb(c, 0, 1);
        c = setb(c, 0, 5);
        shift_bits(c, 48);
        push_commit(c, 1'b1);
        nbusy = 0;
        cfg_latch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cfg_latch = 1'b0;
            obs = snap();
            e   = exp_q.pop_front();
            if (obs.busy) nbusy++;
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL valid_commit edge k+%0d: got %h need %h", i, obs, e);
            end
        end
        checks++;
        if (nbusy != 3) begin
            fails++;
            $display("FAIL valid_busy_len: got %0d need 3", nbusy);
        end
    endtask

    task automatic test_bad_count();
        logic [L-1:0] c;
        snap_t obs, e;
        c = '0;
        c = setb(c, 2, 0);
        c = setb(c, 2, 2);
        c = setb(c, 1, 3);
        c = setb(c, 0, 1);
        shift_bits(c, 47);
        push_commit(c, 1'b0);
        exp_q.push_back(m);
        cfg_latch = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            cfg_latch = 1'b0;
            obs = snap();
            e   = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL bad_count cyc%0d: got %h need %h", i, obs, e);
            end
        end
        shift_bits(c, 48);
        push_commit(c, 1'b1);
        cfg_latch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cfg_latch = 1'b0;
            obs = snap();
            e   = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL recommit edge k+%0d: got %h need %h", i, obs, e);
            end
        end
    endtask

    task automatic test_bbm();
        logic [L-1:0] ca, cb;
        snap_t obs, e;
        ca = '0;
        ca = setb(ca, 3, 0);
        ca = setb(ca, 6, 4);
        cb = '0;
        cb = setb(cb, 3, 4);
        cb = setb(cb, 6, 4);
        for (int pass = 0; pass < 2; pass++) begin
            shift_bits(pass == 0 ? ca : cb, 48);
            push_commit(pass == 0 ? ca : cb, 1'b1);
            cfg_latch = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                cfg_latch = 1'b0;
                obs = snap();
                e   = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL bbm pass%0d edge k+%0d: got %h need %h", pass, i, obs, e);
                end
                checks++;
                if ((pad_OE & pad_PD) !== 8'h00) begin
                    fails++;
                    $display("FAIL bbm_overlap pass%0d edge k+%0d: got OE&PD=%h need 00", pass, i, pad_OE & pad_PD);
                end
            end
        end
    endtask

    task automatic test_collisions();
        logic [L-1:0] ca, cb;
        snap_t obs, e;
        ca = '0;
        ca = setb(ca, 4, 0);
        ca = setb(ca, 4, 1);
        shift_bits(ca, 48);
        push_commit(ca, 1'b1);
        exp_q.push_back(m);
        cfg_latch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            cfg_latch = (i < 3);
            obs = snap();
            e   = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL busy_latch edge k+%0d: got %h need %h", i, obs, e);
            end
        end
        cb = '0;
        cb = setb(cb, 7, 5);
        cb = setb(cb, 5, 2);
        shift_bits(cb, 48);
        push_commit(cb, 1'b1);
        cfg_latch = 1'b1;
        cfg_shift = 1'b1;
        cfg_sdi   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cfg_latch = 1'b0;
            cfg_shift = 1'b0;
            obs = snap();
            e   = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL latch_shift edge k+%0d: got %h need %h", i, obs, e);
            end
        end
        checks++;
        if (cfg_sdo !== 1'b1) begin
            fails++;
            $display("FAIL latch_shift_sdo: got %b need 1", cfg_sdo);
        end
    endtask

    task automatic test_reset_mid();
        logic [L-1:0] c;
        snap_t obs, e;
        c = '0;
        c = setb(c, 1, 0);
        c = setb(c, 1, 1);
        c = setb(c, 1, 2);
        c = setb(c, 7, 5);
        shift_bits(c, 48);
        push_commit(c, 1'b1);
        cfg_latch = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            cfg_latch = 1'b0;
            obs = snap();
            e   = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL pre_reset edge k+%0d: got %h need %h", i, obs, e);
            end
        end
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        obs = snap();
        checks++;
        if (obs !== rst_snap || cfg_sdo !== 1'b0 || core_in !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset_async: got %h sdo=%b cin=%h need %h sdo=0 cin=00", obs, cfg_sdo, core_in, rst_snap);
        end
        tick();
        rst_n = 1'b1;
        m     = rst_snap;
        for (int i = 0; i < 3; i++) tick();
        obs = snap();
        checks++;
        if (obs !== m) begin
            fails++;
            $display("FAIL post_reset_idle: got %h need %h", obs, m);
        end
    endtask

    task automatic test_input_path();
        logic [L-1:0] c;
        logic [N-1:0] prev_y, v, got;
        snap_t obs, e;
        pad_Y = 8'h00;
        tick();
        tick();
        for (int pass = 0; pass < 2; pass++) begin
            prev_y = pad_Y;
            for (int i = 0; i < 10; i++) begin
                v        = 8'($urandom);
                v[5]     = i[0];
                pad_Y    = v;
                core_out = 8'($urandom);
                cin_q.push_back(prev_y & m.ie);
                a_q.push_back(core_out);
                prev_y = v;
                tick();
                got = cin_q.pop_front();
                checks++;
                if (core_in !== got) begin
                    fails++;
                    $display("FAIL core_in pass%0d cyc%0d: got %h need %h", pass, i, core_in, got);
                end
                got = a_q.pop_front();
                checks++;
                if (pad_A !== got) begin
                    fails++;
                    $display("FAIL pad_A pass%0d cyc%0d: got %h need %h", pass, i, pad_A, got);
                end
            end
            if (pass == 0) begin
                c = '0;
                c = setb(c, 5, 1);
                c = setb(c, 0, 1);
                shift_bits(c, 48);
                push_commit(c, 1'b1);
                cfg_latch = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    tick();
                    cfg_latch = 1'b0;
                    obs = snap();
                    e   = exp_q.pop_front();
                    checks++;
                    if (obs !== e) begin
                        fails++;
                        $display("FAIL ie_commit edge k+%0d: got %h need %h", i, obs, e);
                    end
                end
                tick();
                tick();
            end
        end
    endtask

    initial begin
        rst_snap    = '0;
        rst_snap.pd = '1;
        m           = rst_snap;
        test_reset();
        test_valid_commit();
        test_bad_count();
        test_bbm();
        test_collisions();
        test_reset_mid();
        test_input_path();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
